pong_game_ctrl: RTL and testbench

Frame-rate game sequencer for the Pong display path. Owns all game state: ball position and direction, paddle positions, scores and match phase. Advances that state once per video frame on `frame_tick`. Its registered outputs feed the pixel colour generator directly and stay constant between ticks, so every rendered frame shows one consistent state.

---
 rtl/pong_game_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Frame-rate Pong sequencer: owns ball, paddles, scores and match phase.
// Advances once per frame_tick; start acts immediately in IDLE/OVER. Outputs are registered and frame-stable.
module pong_game_ctrl #(
    parameter int FIELD_X_BEGIN      = 8,
    parameter int FIELD_X_END        = 631,
    parameter int FIELD_Y_BEGIN      = 8,
    parameter int FIELD_Y_END        = 471,
    parameter int BALL_RADIUS        = 4,
    parameter int PADDLE_RADIUS      = 24,
    parameter int PADDLE_THICKNESS   = 6,
    parameter int LEFT_PADDLE_BEGIN  = 24,
    parameter int RIGHT_PADDLE_BEGIN = 610,
    parameter int PADDLE_STEP        = 4,
    parameter int BALL_STEP          = 2,
    parameter int WIN_SCORE          = 9,
    parameter int SERVE_FRAMES       = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       left_up,
    input  logic       left_down,
    input  logic       right_up,
    input  logic       right_down,
    output logic [9:0] ball_loc_x,
    output logic [9:0] ball_loc_y,
    output logic [9:0] left_paddle_loc,
    output logic [9:0] right_paddle_loc,
    output logic [3:0] left_score,
    output logic [3:0] right_score,
    output logic [1:0] state,
    output logic       game_over
);
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;
    typedef logic signed [10:0] s11_t;

    localparam int   L_FACE    = LEFT_PADDLE_BEGIN + PADDLE_THICKNESS;
    localparam s11_t R         = s11_t'(BALL_RADIUS);
    localparam s11_t BSTEP     = s11_t'(BALL_STEP);
    localparam s11_t LF        = s11_t'(L_FACE);
    localparam s11_t RPB       = s11_t'(RIGHT_PADDLE_BEGIN);
    localparam s11_t FXB       = s11_t'(FIELD_X_BEGIN);
    localparam s11_t FXE       = s11_t'(FIELD_X_END);
    localparam s11_t FYB       = s11_t'(FIELD_Y_BEGIN);
    localparam s11_t FYE       = s11_t'(FIELD_Y_END);
    localparam s11_t SPAN      = s11_t'(PADDLE_RADIUS + BALL_RADIUS);
    localparam s11_t TOP_CLAMP = s11_t'(FIELD_Y_BEGIN + BALL_RADIUS + 1);
    localparam s11_t BOT_CLAMP = s11_t'(FIELD_Y_END - BALL_RADIUS - 1);
    localparam s11_t L_BOUNCE  = s11_t'(L_FACE + BALL_RADIUS + 1);
    localparam s11_t R_BOUNCE  = s11_t'(RIGHT_PADDLE_BEGIN - BALL_RADIUS - 1);
    localparam int   PAD_MIN   = FIELD_Y_BEGIN + PADDLE_RADIUS;
    localparam int   PAD_MAX   = FIELD_Y_END - PADDLE_RADIUS;
    localparam logic [9:0] CX  = 10'd320;
    localparam logic [9:0] CY  = 10'd240;
    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);

    state_t     st;
    logic       dx, dy;     // dx=1 right, dy=1 down
    logic [7:0] cnt;

    s11_t cx, nx0, ny, nx, ldist, rdist, labs, rabs;
    logic ndx, ndy, goal_l, goal_r, win;
    logic [3:0] ls_inc, rs_inc;

    assign state = st;

    function automatic logic [9:0] pad_next(input logic [9:0] p, input logic up, input logic dn);
        int t;
        t = int'(p);
        if (up && !dn)
            t = (t - PADDLE_STEP < PAD_MIN) ? PAD_MIN : t - PADDLE_STEP;
        else if (dn && !up)
            t = (t + PADDLE_STEP > PAD_MAX) ? PAD_MAX : t + PADDLE_STEP;
        return 10'(t);
    endfunction

    always_comb begin
        cx  = s11_t'({1'b0, ball_loc_x});
        nx0 = dx ? cx + BSTEP : cx - BSTEP;
        ny  = dy ? s11_t'({1'b0, ball_loc_y}) + BSTEP : s11_t'({1'b0, ball_loc_y}) - BSTEP;
        ndy = dy;
        if (!dy && ny - R <= FYB) begin
            ny  = TOP_CLAMP;
            ndy = 1'b1;
        end else if (dy && ny + R >= FYE) begin
            ny  = BOT_CLAMP;
            ndy = 1'b0;
        end
        // Paddle span is tested against the paddle position held before this tick
        ldist = ny - s11_t'({1'b0, left_paddle_loc});
        rdist = ny - s11_t'({1'b0, right_paddle_loc});
        labs  = ldist[10] ? -ldist : ldist;
        rabs  = rdist[10] ? -rdist : rdist;
        nx    = nx0;
        ndx   = dx;
        if (!dx && cx - R > LF && nx0 - R <= LF && labs <= SPAN) begin
            nx  = L_BOUNCE;
            ndx = 1'b1;
        end
        if (dx && cx + R < RPB && nx0 + R >= RPB && rabs <= SPAN) begin
            nx  = R_BOUNCE;
            ndx = 1'b0;
        end
        goal_r = !dx && (nx0 - R <= FXB);
        goal_l = dx && (nx0 + R >= FXE);
        ls_inc = left_score + 4'd1;
        rs_inc = right_score + 4'd1;
        win    = goal_l ? (ls_inc == 4'(WIN_SCORE)) : (rs_inc == 4'(WIN_SCORE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st               <= IDLE;
            game_over        <= 1'b0;
            ball_loc_x       <= CX;
            ball_loc_y       <= CY;
            left_paddle_loc  <= CY;
            right_paddle_loc <= CY;
            left_score       <= 4'd0;
            right_score      <= 4'd0;
            dx               <= 1'b1;
            dy               <= 1'b0;
            cnt              <= 8'd0;
        end else if ((st == IDLE || st == OVER) && start) begin
            st               <= SERVE;
            game_over        <= 1'b0;
            ball_loc_x       <= CX;
            ball_loc_y       <= CY;
            left_paddle_loc  <= CY;
            right_paddle_loc <= CY;
            left_score       <= 4'd0;
            right_score      <= 4'd0;
            dx               <= 1'b1;
            dy               <= 1'b0;
            cnt              <= SERVE_LOAD;
        end else if (frame_tick && (st == SERVE || st == PLAY)) begin
            left_paddle_loc  <= pad_next(left_paddle_loc, left_up, left_down);
            right_paddle_loc <= pad_next(right_paddle_loc, right_up, right_down);
            if (st == SERVE) begin
                if (cnt == 8'd0) st <= PLAY;
                else             cnt <= cnt - 8'd1;
            end else if (goal_l || goal_r) begin
                // Goal overrides wall/paddle results; serve heads toward the side that conceded
                ball_loc_x <= CX;
                ball_loc_y <= CY;
                dx         <= goal_l;
                if (goal_l) left_score  <= ls_inc;
                else        right_score <= rs_inc;
                if (win) begin
                    st        <= OVER;
                    game_over <= 1'b1;
                end else begin
                    st  <= SERVE;
                    cnt <= SERVE_LOAD;
                end
            end else begin
                ball_loc_x <= nx[9:0];
                ball_loc_y <= ny[9:0];
                dx         <= ndx;
                dy         <= ndy;
            end
        end
    end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: serve, paddle clamps, walls, paddle hits, goals, game over, reset.
module tb_pong_game_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0, start = 1'b0;
    logic       left_up = 1'b0, left_down = 1'b0, right_up = 1'b0, right_down = 1'b0;
    logic [9:0] ball_loc_x, ball_loc_y, left_paddle_loc, right_paddle_loc;
    logic [3:0] left_score, right_score;
    logic [1:0] state;
    logic       game_over;
    int         total = 0;
    int         bad = 0;

    pong_game_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .left_up(left_up), .left_down(left_down), .right_up(right_up), .right_down(right_down),
        .ball_loc_x(ball_loc_x), .ball_loc_y(ball_loc_y),
        .left_paddle_loc(left_paddle_loc), .right_paddle_loc(right_paddle_loc),
        .left_score(left_score), .right_score(right_score),
        .state(state), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task tick();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
    endtask

    task ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task test_reset();
        #12;
        total++;
        if ({state, game_over, left_score, right_score} !== {2'd0, 1'b0, 4'd0, 4'd0}) begin
            bad++; $display("FAIL reset_state got st=%0d go=%0d ls=%0d rs=%0d exp 0 0 0 0", state, game_over, left_score, right_score);
        end
        total++;
        if ({ball_loc_x, ball_loc_y, left_paddle_loc, right_paddle_loc} !== {10'd320, 10'd240, 10'd240, 10'd240}) begin
            bad++; $display("FAIL reset_pos got x=%0d y=%0d lp=%0d rp=%0d exp 320 240 240 240", ball_loc_x, ball_loc_y, left_paddle_loc, right_paddle_loc);
        end
        reset = 1'b0;
    endtask

    task test_serve();
        pulse_start();
        total++;
        if (state !== 2'd1) begin bad++; $display("FAIL serve_enter got st=%0d exp 1", state); end
        ticks(30);
        pulse_start();
        ticks(30);
        total++;
        if ({state, ball_loc_x, ball_loc_y} !== {2'd1, 10'd320, 10'd240}) begin
            bad++; $display("FAIL serve_60 got st=%0d x=%0d y=%0d exp 1 320 240", state, ball_loc_x, ball_loc_y);
        end
        tick();
        total++;
        if ({state, ball_loc_x, ball_loc_y} !== {2'd2, 10'd320, 10'd240}) begin
            bad++; $display("FAIL serve_61 got st=%0d x=%0d y=%0d exp 2 320 240", state, ball_loc_x, ball_loc_y);
        end
        tick();
        total++;
        if ({ball_loc_x, ball_loc_y} !== {10'd322, 10'd238}) begin
            bad++; $display("FAIL play_first_move got x=%0d y=%0d exp 322 238", ball_loc_x, ball_loc_y);
        end
        pulse_start();
        total++;
        if ({state, ball_loc_x, ball_loc_y} !== {2'd2, 10'd322, 10'd238}) begin
            bad++; $display("FAIL start_in_play got st=%0d x=%0d y=%0d exp 2 322 238", state, ball_loc_x, ball_loc_y);
        end
    endtask

    task test_paddle_clamp();
        do_reset();
        pulse_start();
        left_up = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 51) begin
                total++;
                if (left_paddle_loc !== 10'd36) begin bad++; $display("FAIL lp_tick51 got %0d exp 36", left_paddle_loc); end
            end
            if (i == 52) begin
                total++;
                if (left_paddle_loc !== 10'd32) begin bad++; $display("FAIL lp_tick52 got %0d exp 32", left_paddle_loc); end
            end
        end
        total++;
        if ({left_paddle_loc, right_paddle_loc, state} !== {10'd32, 10'd240, 2'd1}) begin
            bad++; $display("FAIL lp_floor got lp=%0d rp=%0d st=%0d exp 32 240 1", left_paddle_loc, right_paddle_loc, state);
        end
        left_down = 1'b1;
        tick();
        total++;
        if (left_paddle_loc !== 10'd32) begin bad++; $display("FAIL lp_both got %0d exp 32", left_paddle_loc); end
        left_up = 1'b0;
        tick();
        total++;
        if (left_paddle_loc !== 10'd36) begin bad++; $display("FAIL lp_down got %0d exp 36", left_paddle_loc); end
        left_down = 1'b0;
    endtask

    task test_wall_and_paddles();
        do_reset();
        pulse_start();
        right_up = 1'b1;
        ticks(40);
        right_up = 1'b0;
        total++;
        if (right_paddle_loc !== 10'd80) begin bad++; $display("FAIL rp_80 got %0d exp 80", right_paddle_loc); end
        ticks(21);
        total++;
        if (state !== 2'd2) begin bad++; $display("FAIL play_enter got st=%0d exp 2", state); end
        for (int k = 1; k <= 143; k++) begin
            tick();
            if (k == 113) begin
                total++;
                if ({ball_loc_x, ball_loc_y} !== {10'd546, 10'd14}) begin
                    bad++; $display("FAIL wall_113 got x=%0d y=%0d exp 546 14", ball_loc_x, ball_loc_y);
                end
            end
            if (k == 114) begin
                total++;
                if ({ball_loc_x, ball_loc_y} !== {10'd548, 10'd13}) begin
                    bad++; $display("FAIL wall_114 got x=%0d y=%0d exp 548 13", ball_loc_x, ball_loc_y);
                end
            end
            if (k == 115) begin
                total++;
                if (ball_loc_y !== 10'd15) begin bad++; $display("FAIL wall_115 got y=%0d exp 15", ball_loc_y); end
            end
        end
        total++;
        if ({ball_loc_x, ball_loc_y} !== {10'd605, 10'd71}) begin
            bad++; $display("FAIL rhit got x=%0d y=%0d exp 605 71", ball_loc_x, ball_loc_y);
        end
        for (int j = 1; j <= 286; j++) begin
            left_down = (j <= 13);
            tick();
            if (j == 1) begin
                total++;
                if ({ball_loc_x, ball_loc_y} !== {10'd603, 10'd73}) begin
                    bad++; $display("FAIL rhit_after got x=%0d y=%0d exp 603 73", ball_loc_x, ball_loc_y);
                end
            end
            if (j == 13) begin
                total++;
                if (left_paddle_loc !== 10'd292) begin bad++; $display("FAIL lp_292 got %0d exp 292", left_paddle_loc); end
            end
            if (j == 198) begin
                total++;
                if ({ball_loc_x, ball_loc_y} !== {10'd209, 10'd466}) begin
                    bad++; $display("FAIL bottom_wall got x=%0d y=%0d exp 209 466", ball_loc_x, ball_loc_y);
                end
            end
        end
        left_down = 1'b0;
        total++;
        if ({ball_loc_x, ball_loc_y, state} !== {10'd35, 10'd290, 2'd2}) begin
            bad++; $display("FAIL lhit got x=%0d y=%0d st=%0d exp 35 290 2", ball_loc_x, ball_loc_y, state);
        end
        tick();
        total++;
        if ({ball_loc_x, ball_loc_y} !== {10'd37, 10'd288}) begin
            bad++; $display("FAIL lhit_after got x=%0d y=%0d exp 37 288", ball_loc_x, ball_loc_y);
        end
    endtask

    task test_reset_mid_play();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({state, ball_loc_x, ball_loc_y, left_paddle_loc, right_paddle_loc, left_score, right_score}
            !== {2'd0, 10'd320, 10'd240, 10'd240, 10'd240, 4'd0, 4'd0}) begin
            bad++; $display("FAIL reset_mid got st=%0d x=%0d y=%0d lp=%0d rp=%0d exp 0 320 240 240 240",
                            state, ball_loc_x, ball_loc_y, left_paddle_loc, right_paddle_loc);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task test_goal_game_over();
        do_reset();
        pulse_start();
        ticks(61 + 153);
        total++;
        if ({left_score, state} !== {4'd0, 2'd2}) begin
            bad++; $display("FAIL pre_goal got ls=%0d st=%0d exp 0 2", left_score, state);
        end
        tick();
        total++;
        if ({left_score, right_score, state, ball_loc_x, ball_loc_y, game_over} !== {4'd1, 4'd0, 2'd1, 10'd320, 10'd240, 1'b0}) begin
            bad++; $display("FAIL goal1 got ls=%0d rs=%0d st=%0d x=%0d y=%0d go=%0d exp 1 0 1 320 240 0",
                            left_score, right_score, state, ball_loc_x, ball_loc_y, game_over);
        end
        ticks(62);
        total++;
        if ({ball_loc_x, ball_loc_y} !== {10'd322, 10'd242}) begin
            bad++; $display("FAIL serve2_dir got x=%0d y=%0d exp 322 242", ball_loc_x, ball_loc_y);
        end
        ticks(153);
        total++;
        if ({left_score, state} !== {4'd2, 2'd1}) begin
            bad++; $display("FAIL goal2 got ls=%0d st=%0d exp 2 1", left_score, state);
        end
        for (int r = 3; r <= 9; r++) ticks(215);
        total++;
        if ({left_score, right_score, state, game_over, ball_loc_x, ball_loc_y} !== {4'd9, 4'd0, 2'd3, 1'b1, 10'd320, 10'd240}) begin
            bad++; $display("FAIL game_over got ls=%0d rs=%0d st=%0d go=%0d x=%0d y=%0d exp 9 0 3 1 320 240",
                            left_score, right_score, state, game_over, ball_loc_x, ball_loc_y);
        end
        left_up = 1'b1;
        ticks(5);
        left_up = 1'b0;
        total++;
        if ({left_score, state, ball_loc_x, left_paddle_loc} !== {4'd9, 2'd3, 10'd320, 10'd240}) begin
            bad++; $display("FAIL over_frozen got ls=%0d st=%0d x=%0d lp=%0d exp 9 3 320 240", left_score, state, ball_loc_x, left_paddle_loc);
        end
        pulse_start();
        total++;
        if ({state, left_score, game_over} !== {2'd1, 4'd0, 1'b0}) begin
            bad++; $display("FAIL restart got st=%0d ls=%0d go=%0d exp 1 0 0", state, left_score, game_over);
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_paddle_clamp();
        test_wall_and_paddles();
        test_reset_mid_play();
        test_goal_game_over();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
